// File: rtl/ram_load_arbiter.sv
// Arbitrates the program RAM between the CPU and an external loader port.
// A load session freezes the CPU at an instruction boundary and ends with a CPU reset pulse.
module ram_load_arbiter #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int RST_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_req,
    input  logic              cpu_boundary,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              prog_valid,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_sel,
    output logic              cpu_hold,
    output logic              cpu_reset,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {
        RUN,
        WAIT_BND,
        LOAD,
        RELEASE
    } state_t;

    localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [3:0]      REL_LAST = 4'(RST_CYCLES - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] load_addr;
    logic [3:0]        rel_cnt;
    logic              accept;

    // Ownership outputs decode straight from the state register, so they
    // change exactly one cycle after the decision that caused them.
    assign ram_sel    = (state == LOAD) || (state == RELEASE);
    assign cpu_hold   = ram_sel;
    assign cpu_reset  = (state == RELEASE);
    assign prog_ready = (state == LOAD) && (word_count < DEPTH);
    assign accept     = prog_valid && prog_ready;
    assign ram_addr   = ram_sel ? load_addr : cpu_addr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (load_req) state_next = WAIT_BND;
            end
            WAIT_BND: begin
                if (!load_req)        state_next = RUN;
                else if (cpu_boundary) state_next = LOAD;
            end
            LOAD: begin
                // A word accepted on the drop cycle is still written before exit.
                if (!load_req && !accept) state_next = RELEASE;
            end
            RELEASE: begin
                if (rel_cnt == REL_LAST) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ram_we     <= 1'b0;
            ram_wdata  <= '0;
            load_addr  <= '0;
            word_count <= '0;
            rel_cnt    <= '0;
        end else begin
            ram_we <= accept;
            if (accept) begin
                load_addr  <= prog_addr;
                ram_wdata  <= prog_data;
                word_count <= word_count + 1'b1;
            end
            if (state == WAIT_BND && state_next == LOAD) begin
                word_count <= '0;
            end
            rel_cnt <= (state == RELEASE) ? rel_cnt + 1'b1 : '0;
        end
    end

endmodule

// File: tb/tb_ram_load_arbiter.sv
// Randomized bench for ram_load_arbiter: expected RAM writes go into a scoreboard
// queue at handshake time and a negedge monitor retires them against ram_we.
module tb_ram_load_arbiter;

    localparam int ADDR_W     = 4;
    localparam int DATA_W     = 8;
    localparam int RST_CYCLES = 2;
    localparam int DEPTH      = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clock;
    logic              reset;
    logic              load_req;
    logic              cpu_boundary;
    logic [ADDR_W-1:0] cpu_addr;
    logic              prog_valid;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              prog_ready;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic              ram_sel;
    logic              cpu_hold;
    logic              cpu_reset;
    logic [ADDR_W:0]   word_count;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  mc     = 0;   // words the reference model has accepted this session

    ram_load_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .load_req    (load_req),
        .cpu_boundary(cpu_boundary),
        .cpu_addr    (cpu_addr),
        .prog_valid  (prog_valid),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_ready  (prog_ready),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_we      (ram_we),
        .ram_sel     (ram_sel),
        .cpu_hold    (cpu_hold),
        .cpu_reset   (cpu_reset),
        .word_count  (word_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every RAM write must match the oldest outstanding expected word.
    always @(negedge clock) begin
        if (ram_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", int'(ram_addr), int'(e.addr));
                check("wr_data", int'(ram_wdata), int'(e.data));
                check("wr_sel", int'(ram_sel), 1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic start_load(input int waitc);
        load_req     = 1'b1;
        cpu_boundary = 1'b0;
        for (int i = 0; i < waitc; i++) begin
            @(negedge clock);
            check("bnd_wait_hold", int'(cpu_hold), 0);
            check("bnd_wait_ready", int'(prog_ready), 0);
        end
        cpu_boundary = 1'b1;
        @(negedge clock);
        check("entry_hold", int'(cpu_hold), 1);
        check("entry_sel", int'(ram_sel), 1);
        check("entry_ready", int'(prog_ready), 1);
        check("entry_count", int'(word_count), 0);
        cpu_boundary = 1'b0;
        mc = 0;
    endtask

    task automatic send_words(input int n, input bit fixed, input bit drop_last);
        logic [ADDR_W-1:0] tab_a [4];
        logic [DATA_W-1:0] tab_d [4];
        tab_a = '{4'h0, 4'h1, 4'h2, 4'hF};
        tab_d = '{8'h0E, 8'h1F, 8'h2F, 8'hF0};
        for (int i = 0; i < n; i++) begin
            logic [ADDR_W-1:0] a;
            logic [DATA_W-1:0] d;
            bit acc;
            if (!fixed && $urandom_range(0, 3) == 0) begin
                prog_valid = 1'b0;
                @(negedge clock);
            end
            a = fixed ? tab_a[i % 4] : ADDR_W'($urandom_range(0, DEPTH - 1));
            d = fixed ? tab_d[i % 4] : DATA_W'($urandom);
            acc = (mc < DEPTH);
            check("prog_ready", int'(prog_ready), int'(acc));
            prog_valid = 1'b1;
            prog_addr  = a;
            prog_data  = d;
            if (drop_last && i == n - 1) load_req = 1'b0;
            if (acc) begin
                exp_q.push_back('{addr: a, data: d});
                mc++;
            end
            @(negedge clock);
            check("we_latency", int'(ram_we), int'(acc));
        end
        prog_valid = 1'b0;
        check("word_count", int'(word_count), mc);
    endtask

    task automatic finish_load(input bit dropped, input bit req_in_rel);
        if (dropped) begin
            check("drop_hs_reset", int'(cpu_reset), 0);
            check("drop_hs_hold", int'(cpu_hold), 1);
        end else begin
            load_req = 1'b0;
        end
        for (int r = 0; r < RST_CYCLES; r++) begin
            @(negedge clock);
            check("rel_cpu_reset", int'(cpu_reset), 1);
            check("rel_hold", int'(cpu_hold), 1);
            check("rel_sel", int'(ram_sel), 1);
            check("rel_ready", int'(prog_ready), 0);
            check("rel_we", int'(ram_we), 0);
            if (req_in_rel) load_req = 1'b1;
        end
        @(negedge clock);
        check("run_cpu_reset", int'(cpu_reset), 0);
        check("run_hold", int'(cpu_hold), 0);
        check("run_sel", int'(ram_sel), 0);
        check("run_count", int'(word_count), mc);
        if (req_in_rel) begin
            load_req = 1'b0;
            @(negedge clock);
            check("rerun_hold", int'(cpu_hold), 0);
            check("rerun_count", int'(word_count), mc);
            @(negedge clock);
            check("rerun_sel", int'(ram_sel), 0);
        end
    endtask

    initial begin
        reset        = 1'b1;
        load_req     = 1'b0;
        cpu_boundary = 1'b0;
        cpu_addr     = 4'h3;
        prog_valid   = 1'b0;
        prog_addr    = '0;
        prog_data    = '0;
        repeat (2) @(negedge clock);
        check("rst_ready", int'(prog_ready), 0);
        check("rst_we", int'(ram_we), 0);
        check("rst_wdata", int'(ram_wdata), 0);
        check("rst_sel", int'(ram_sel), 0);
        check("rst_hold", int'(cpu_hold), 0);
        check("rst_cpu_reset", int'(cpu_reset), 0);
        check("rst_count", int'(word_count), 0);
        reset = 1'b0;

        // Idle pass-through, with stray loader traffic that must be ignored.
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("idle_addr", int'(ram_addr), int'(cpu_addr));
            check("idle_sel", int'(ram_sel), 0);
            check("idle_we", int'(ram_we), 0);
            check("idle_hold", int'(cpu_hold), 0);
            cpu_addr     = (i < 10) ? 4'h3 : ADDR_W'($urandom);
            prog_valid   = 1'($urandom);
            prog_addr    = ADDR_W'($urandom);
            prog_data    = DATA_W'($urandom);
            cpu_boundary = 1'($urandom);
        end
        prog_valid   = 1'b0;
        cpu_boundary = 1'b0;

        // Boundary wait then fixed burst.
        @(negedge clock);
        start_load(4);
        send_words(4, 1'b1, 1'b0);
        check("burst_count", int'(word_count), 4);
        finish_load(1'b0, 1'b0);

        // Saturation: 17 offered, 16 accepted.
        start_load(2);
        send_words(17, 1'b0, 1'b0);
        check("sat_ready", int'(prog_ready), 0);
        check("sat_count", int'(word_count), DEPTH);
        finish_load(1'b0, 1'b0);

        // Release after 3 words, load_req dropped on the last handshake,
        // and a new request raised during RELEASE.
        start_load(1);
        send_words(3, 1'b0, 1'b1);
        finish_load(1'b1, 1'b1);
        check("release_count", int'(word_count), 3);

        // Abort in WAIT_BND; boundary seen after the drop must not start a load.
        load_req = 1'b1;
        @(negedge clock);
        check("abort_wait_hold", int'(cpu_hold), 0);
        load_req     = 1'b0;
        cpu_boundary = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("abort_hold", int'(cpu_hold), 0);
            check("abort_sel", int'(ram_sel), 0);
        end
        cpu_boundary = 1'b0;

        // Reset one cycle after a handshake, with a second word offered alongside it.
        start_load(2);
        send_words(1, 1'b0, 1'b0);
        reset      = 1'b1;
        prog_valid = 1'b1;
        prog_addr  = ADDR_W'($urandom);
        prog_data  = DATA_W'($urandom);
        @(negedge clock);
        check("mid_rst_we", int'(ram_we), 0);
        check("mid_rst_hold", int'(cpu_hold), 0);
        check("mid_rst_sel", int'(ram_sel), 0);
        check("mid_rst_ready", int'(prog_ready), 0);
        check("mid_rst_cpu_reset", int'(cpu_reset), 0);
        check("mid_rst_count", int'(word_count), 0);
        check("mid_rst_wdata", int'(ram_wdata), 0);
        check("mid_rst_addr", int'(ram_addr), int'(cpu_addr));
        reset      = 1'b0;
        prog_valid = 1'b0;
        load_req   = 1'b0;
        mc         = 0;
        @(negedge clock);
        check("post_rst_we", int'(ram_we), 0);
        check("post_rst_hold", int'(cpu_hold), 0);

        // Random sessions.
        for (int s = 0; s < 12; s++) begin
            int  n;
            bit  drop;
            n    = $urandom_range(0, 20);
            drop = (n > 0) && ($urandom_range(0, 1) == 1);
            start_load($urandom_range(1, 4));
            send_words(n, 1'b0, drop);
            finish_load(drop, 1'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        repeat (3) @(negedge clock);
        check("sb_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
